mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port instruction/data memory between the fetch stage
//   (IF port) and the memory stage (DM port) of the 5-stage pipeline.
//   Arbitrates requests and drives the fixed-latency memory.
//   Returns read data to the winning requester.
//   Raises stall_fe/stall_me toward the hazard unit while a requester waits.
// PARAMETERS
//   ADDR_W      32  address width, both ports and the memory
//   DATA_W      32  data width
//   MEM_LAT      2  memory read latency in cycles, mem_en to mem_rdata valid (range 1..7)
//   STARVE_MAX   4  consecutive DM wins while IF waits before IF is forced (range 1..15)
// PORTS
//   clk        in   1       clock; one clock domain
//   rst        in   1       reset, asynchronous, active-low
//   if_req     in   1       fetch read request; held until if_gnt
//   if_addr    in   ADDR_W  fetch address; stable while if_req=1
//   if_gnt     out  1       one-cycle pulse: IF request issued to memory
//   if_rvalid  out  1       one-cycle pulse: if_rdata valid
//   if_rdata   out  DATA_W  fetched instruction word
//   dm_req     in   1       data request; held until dm_gnt
//   dm_we      in   1       1=write, 0=read; stable while dm_req=1
//   dm_addr    in   ADDR_W  data address
//   dm_wdata   in   DATA_W  store data
//   dm_gnt     out  1       one-cycle pulse: DM request issued
//   dm_rvalid  out  1       one-cycle pulse: dm_rdata valid (reads only)
//   dm_rdata   out  DATA_W  load data
//   mem_en     out  1       memory access strobe, one cycle per access
//   mem_we     out  1       memory write enable, qualified by mem_en
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//   stall_fe   out  1       fetch must hold
//   stall_me   out  1       memory stage must hold
// BEHAVIOUR
//   - Reset (rst=0, async): all outputs 0; FSM=IDLE; starve_cnt=0.
//     Any in-flight read is dropped; no rvalid is produced for it.
//   - FSM states:
//       IDLE    = arbitrating.
//       RD_WAIT = read outstanding; lat_cnt counts down from MEM_LAT-1.
//   - Grant rules, evaluated in IDLE and in the last RD_WAIT cycle:
//       DM only           -> DM wins.
//       IF only           -> IF wins.
//       Both requesting   -> DM wins, unless starve_cnt==STARVE_MAX; then IF wins.
//   - Grant cycle t: gnt pulse; mem_en=1; mem_addr/mem_we/mem_wdata taken
//     from the winner. mem_we=0 for IF.
//   - Read grant: FSM->RD_WAIT. At t+MEM_LAT the winner sees rvalid=1 with
//     rdata=mem_rdata. The same cycle may issue the next grant, so read
//     throughput is 1 per MEM_LAT cycles.
//   - Write grant: completes at t. No rvalid. FSM stays IDLE, so the next
//     grant is possible at t+1.
//   - Only one access is outstanding. gnt and mem_en never fire while
//     RD_WAIT has lat_cnt>0.
//   - starve_cnt (4 bit):
//       +1 on each DM grant while if_req=1, saturating at STARVE_MAX.
//       Cleared on IF grant, or when if_req=0.
//   - stall_fe = if_req & ~if_rvalid.
//   - stall_me = dm_req & ~(dm_we ? dm_gnt : dm_rvalid).
//   - Dropping req before gnt is a protocol violation. Behaviour is unspecified.
//   - if_rdata/dm_rdata hold their last value between rvalid pulses.
// STRUCTURE
//   - Constants.v: `define MEM_LAT_DEF, STARVE_MAX_DEF, and the FSM encodings
//     ARB_IDLE and ARB_RD_WAIT.
//   - Sub-module mem_lat_timer: loadable down-counter. Outputs done on the
//     last RD_WAIT cycle.
//   - The owner tag (IF/DM) for the outstanding read is registered at grant.
// TESTING
//   - Reset mid-read: IF read granted, rst=0 at t+1 -> all outputs 0,
//     no if_rvalid, IDLE after release.
//   - IF-only read, MEM_LAT=2, addr 0x40, mem_rdata=0x00500093:
//     if_gnt@t, if_rvalid@t+2, if_rdata=0x00500093, stall_fe 1 until t+2.
//   - Concurrent requests: DM read 0x100 and IF 0x44 both at t ->
//     dm_gnt@t, dm_rvalid@t+2, if_gnt@t+2, if_rvalid@t+4.
//   - DM write 0x200 data 0xDEADBEEF: mem_en=mem_we=1@t, no dm_rvalid,
//     stall_me=0@t, pending IF granted at t+1.
//   - Starvation, STARVE_MAX=4: IF and DM requesting continuously ->
//     4 dm_gnt, then 1 if_gnt, starve_cnt back to 0, pattern repeats.
//   - Back-to-back DM reads, MEM_LAT=1: one dm_gnt per cycle;
//     dm_rvalid trails each dm_gnt by exactly 1 cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
// FSM encodings are plain localparams so older tools and checkers can bind to them.
package mem_port_arbiter_pkg;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;
  localparam int LAT_CNT_W      = 3;
  localparam int STARVE_W       = 4;

  localparam logic [0:0] ARB_IDLE    = 1'b0;
  localparam logic [0:0] ARB_RD_WAIT = 1'b1;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Loadable down-counter that times the outstanding memory read.
// done is high on the final cycle of the read wait, when mem_rdata is valid.
module mem_lat_timer
  import mem_port_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 run,
  output logic                 done
);

  logic [LAT_CNT_W-1:0] cnt_q;

  // A reload in the done cycle wins so back-to-back reads keep full throughput.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (run && (cnt_q != '0)) begin
      cnt_q <= cnt_q - LAT_CNT_W'(1);
    end
  end

  assign done = run & (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (IF) and memory-stage (DM) ports onto one fixed-latency
// single-port memory, returns read data to the owner and raises pipeline stalls.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_fe,
  output logic                stall_me,
  output logic [0:0]          dbg_state,
  output logic [STARVE_W-1:0] dbg_starve_cnt
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD   = LAT_CNT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0]  STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [0:0]          state_q;
  logic [0:0]          state_d;
  logic [STARVE_W-1:0] starve_q;
  owner_e              owner_q;
  logic                timer_done;
  logic                can_grant;
  logic                if_win;
  logic                dm_win;
  logic                rd_grant;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;

  // Handshake: a requester holds req (and its address/data) until it sees gnt;
  // gnt is a single-cycle pulse in the cycle the access is put on the memory,
  // and a read returns exactly one rvalid pulse MEM_LAT cycles later.
  assign can_grant = rst & ((state_q == ARB_IDLE) | timer_done);
  assign if_win    = can_grant & if_req & (~dm_req | (starve_q == STARVE_LIM));
  assign dm_win    = can_grant & dm_req & ~if_win;
  assign rd_grant  = if_win | (dm_win & ~dm_we);

  assign if_gnt = if_win;
  assign dm_gnt = dm_win;

  always_comb begin
    mem_en    = if_win | dm_win;
    mem_we    = dm_win & dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_win) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_we ? dm_wdata : '0;
    end else if (if_win) begin
      mem_addr = if_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    if (can_grant) begin
      state_d = rd_grant ? ARB_RD_WAIT : ARB_IDLE;
    end
  end

  mem_lat_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_grant),
    .load_val (LAT_LOAD),
    .run      (state_q == ARB_RD_WAIT),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      starve_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_grant) begin
        owner_q <= if_win ? OWN_IF : OWN_DM;
      end
      // Only DM wins that leave IF waiting count toward forcing an IF grant.
      if (!if_req || if_win) begin
        starve_q <= '0;
      end else if (dm_win && (starve_q != STARVE_LIM)) begin
        starve_q <= starve_q + STARVE_W'(1);
      end
    end
  end

  assign if_rvalid = timer_done & (owner_q == OWN_IF);
  assign dm_rvalid = timer_done & (owner_q == OWN_DM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (dm_rvalid) dm_rdata_q <= mem_rdata;
    end
  end

  assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
  assign dm_rdata = dm_rvalid ? mem_rdata : dm_rdata_q;

  assign stall_fe = rst & if_req & ~if_rvalid;
  assign stall_me = rst & dm_req & ~(dm_we ? dm_gnt : dm_rvalid);

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule
